// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_pkg
// Description : Shared definitions for the multiply/divide unit: operation
//               encodings, FSM state type and default datapath sizes.
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int ITER_DEF  = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Signed variants are the even encodings (MULT, DIV).
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_iter_core.sv
`default_nettype none
// ============================================================================
// Module      : mdu_iter_core
// Description : 2*WIDTH-bit accumulator with a one-step unsigned datapath:
//               shift-add multiply or restoring shift-subtract divide.
//               Ports:
//                 clk, rst      - clock, synchronous active-high reset
//                 i_load        - load {0, i_a} into the accumulator, latch i_b
//                 i_step        - advance the accumulator by one step
//                 i_is_div      - select divide (1) or multiply (0) step
//                 i_a, i_b      - unsigned magnitudes (multiplier / dividend,
//                                 multiplicand / divisor)
//                 o_acc_next    - accumulator value after the current step
//                                 ({product} or {remainder, quotient})
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_load,
    input  logic                 i_step,
    input  logic                 i_is_div,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic [2*WIDTH-1:0]   o_acc_next
);

    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_rem;
    logic [WIDTH:0]     w_trial;

    always_comb begin
        // Multiply: low half holds remaining multiplier bits; add into the
        // high half when the current LSB is set, then shift right with carry.
        w_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_b};
        // Divide: shift the next dividend bit into the partial remainder and
        // keep the subtraction only if it does not borrow. The partial
        // remainder is below the divisor, so WIDTH+1 bits suffice.
        w_rem   = r_acc[2*WIDTH-1:WIDTH-1];
        w_trial = w_rem - {1'b0, r_b};

        if (i_is_div) begin
            if (!w_trial[WIDTH]) begin
                o_acc_next = {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
            end else begin
                o_acc_next = {w_rem[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (r_acc[0]) begin
                o_acc_next = {w_sum, r_acc[WIDTH-1:1]};
            end else begin
                o_acc_next = {1'b0, r_acc[2*WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_b   <= '0;
        end else if (i_load) begin
            r_acc <= {{WIDTH{1'b0}}, i_a};
            r_b   <= i_b;
        end else if (i_step) begin
            r_acc <= o_acc_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit
// Description : Iterative MIPS-style HI/LO multiply/divide unit. One step per
//               cycle, ITER cycles per operation, plus a one-cycle DONE.
//               Ports:
//                 clk, reset        - clock, synchronous active-high reset
//                 start, op         - launch MULT/MULTU/DIV/DIVU (idle only)
//                 input1, input2    - operand A / dividend, operand B / divisor
//                 mthi, mtlo        - move input1 into HI / LO (idle only)
//                 hi, lo            - result registers
//                 busy, done        - not idle / one-cycle result strobe
//                 div_zero          - sticky divide-by-zero flag
// Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int ITER  = ITER_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  logic             mthi,
    input  logic             mtlo,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int             CW     = $clog2(ITER) + 1;
    localparam logic [CW-1:0]  C_LAST = CW'(ITER - 1);

    state_t             r_state, w_state_nxt;
    logic [CW-1:0]      r_count, w_count_nxt;
    logic               r_is_div, w_is_div_nxt;
    logic               r_neg_q, w_neg_q_nxt;
    logic               r_neg_r, w_neg_r_nxt;
    logic               r_b_zero, w_b_zero_nxt;
    logic [WIDTH-1:0]   r_a, w_a_nxt;
    logic [WIDTH-1:0]   r_hi, w_hi_nxt;
    logic [WIDTH-1:0]   r_lo, w_lo_nxt;
    logic               r_done, w_done_nxt;
    logic               r_div_zero, w_div_zero_nxt;

    logic               w_load;
    logic               w_step;
    logic               w_signed;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [2*WIDTH-1:0] w_acc_nxt;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;

    assign w_load = (r_state == IDLE) && start;
    assign w_step = (r_state == RUN);

    always_comb begin
        w_signed = op_is_signed(op);
        w_mag_a  = (w_signed && input1[WIDTH-1]) ? -input1 : input1;
        w_mag_b  = (w_signed && input2[WIDTH-1]) ? -input2 : input2;
    end

    mdu_iter_core #(
        .WIDTH      (WIDTH)
    ) u_core (
        .clk        (clk),
        .rst        (reset),
        .i_load     (w_load),
        .i_step     (w_step),
        .i_is_div   (r_is_div),
        .i_a        (w_mag_a),
        .i_b        (w_mag_b),
        .o_acc_next (w_acc_nxt)
    );

    // Sign correction of the final magnitude results. Negating 2^(WIDTH-1)
    // wraps to itself, which yields the expected MIN_INT / -1 result.
    always_comb begin
        w_prod = r_neg_q ? -w_acc_nxt : w_acc_nxt;
        w_quot = r_neg_q ? -w_acc_nxt[WIDTH-1:0] : w_acc_nxt[WIDTH-1:0];
        w_rem  = r_neg_r ? -w_acc_nxt[2*WIDTH-1:WIDTH] : w_acc_nxt[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_count_nxt    = r_count;
        w_is_div_nxt   = r_is_div;
        w_neg_q_nxt    = r_neg_q;
        w_neg_r_nxt    = r_neg_r;
        w_b_zero_nxt   = r_b_zero;
        w_a_nxt        = r_a;
        w_hi_nxt       = r_hi;
        w_lo_nxt       = r_lo;
        w_done_nxt     = 1'b0;
        w_div_zero_nxt = r_div_zero;

        case (r_state)
            IDLE: begin
                if (start) begin
                    // Moves presented with start are dropped.
                    w_state_nxt    = RUN;
                    w_count_nxt    = '0;
                    w_is_div_nxt   = op[1];
                    w_neg_q_nxt    = w_signed && (input1[WIDTH-1] ^ input2[WIDTH-1]);
                    w_neg_r_nxt    = w_signed && input1[WIDTH-1];
                    w_b_zero_nxt   = (input2 == '0);
                    w_a_nxt        = input1;
                    w_div_zero_nxt = 1'b0;
                end else begin
                    if (mthi) w_hi_nxt = input1;
                    if (mtlo) w_lo_nxt = input1;
                end
            end
            RUN: begin
                w_count_nxt = r_count + CW'(1);
                if (r_count == C_LAST) begin
                    w_state_nxt = DONE;
                    w_done_nxt  = 1'b1;
                    if (!r_is_div) begin
                        w_hi_nxt = w_prod[2*WIDTH-1:WIDTH];
                        w_lo_nxt = w_prod[WIDTH-1:0];
                    end else if (r_b_zero) begin
                        // Divide by zero returns the untouched dividend.
                        w_hi_nxt       = r_a;
                        w_lo_nxt       = '1;
                        w_div_zero_nxt = 1'b1;
                    end else begin
                        w_hi_nxt = w_rem;
                        w_lo_nxt = w_quot;
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_b_zero   <= 1'b0;
            r_a        <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_is_div   <= w_is_div_nxt;
            r_neg_q    <= w_neg_q_nxt;
            r_neg_r    <= w_neg_r_nxt;
            r_b_zero   <= w_b_zero_nxt;
            r_a        <= w_a_nxt;
            r_hi       <= w_hi_nxt;
            r_lo       <= w_lo_nxt;
            r_done     <= w_done_nxt;
            r_div_zero <= w_div_zero_nxt;
        end
    end

    assign hi       = r_hi;
    assign lo       = r_lo;
    assign busy     = (r_state != IDLE);
    assign done     = r_done;
    assign div_zero = r_div_zero;

endmodule
`default_nettype wire

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameters SHALL be: WIDTH, 32, operand/HI/LO width; ITER, 32, iterations per operation.
REQ-002 Clock and reset SHALL be: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to launch the operation given by op.
REQ-006 op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-007 input1  input  32  operand A (rs); dividend for DIV/DIVU.
REQ-008 input2  input  32  operand B (rt); divisor for DIV/DIVU.
REQ-009 mthi  input  1  write input1 into HI.
REQ-010 mtlo  input  1  write input1 into LO.
REQ-011 hi  output  32  HI register: product upper word, or remainder.
REQ-012 lo  output  32  LO register: product lower word, or quotient.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 done  output  1  one-cycle pulse when hi/lo hold a new result.
REQ-015 div_zero  output  1  sticky flag: last completed DIV/DIVU had divisor 0; cleared by the next start.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-017 IDLE SHALL go to RUN on an edge with start=1, capturing op, input1 and input2 and clearing the iteration counter.
REQ-018 RUN SHALL perform one shift-add (multiply) or one restoring shift-subtract (divide) step per edge, incrementing the counter.
REQ-019 On the ITER-th RUN edge, the unit SHALL write the final hi/lo and enter DONE: start accepted at edge N, hi/lo valid and done=1 after edge N+32.
REQ-020 DONE SHALL last one cycle (done=1, busy=1), then go to IDLE.
REQ-021 start, mthi and mtlo SHALL be ignored while busy=1; a launched operation is never aborted except by reset.
REQ-022 In IDLE, mthi/mtlo SHALL update hi/lo on the next edge; mthi and mtlo together write both.
REQ-023 In IDLE, start together with mthi/mtlo SHALL launch the operation, and the moves SHALL be dropped.
REQ-024 Signed ops SHALL run on magnitudes, then correct the sign: product is negative iff the operand signs differ; quotient is negative iff the signs differ; remainder takes the sign of the dividend.
REQ-025 MULT/MULTU SHALL produce the exact 64-bit product: {hi,lo}.
REQ-026 A divisor of 0 SHALL give lo=32'hFFFFFFFF and hi=input1 (signed or unsigned), set div_zero=1, and keep the normal latency.
REQ-027 DIV of 32'h80000000 by 32'hFFFFFFFF SHALL give lo=32'h80000000 and hi=0, with no flag.
REQ-028 hi and lo SHALL hold their values between writes; intermediate iteration state SHALL NOT appear on hi/lo before DONE.

Reset
REQ-029 When reset=1 at an edge, the unit SHALL go to IDLE with hi=0, lo=0, busy=0, done=0, div_zero=0 and the counter at 0, including in mid-operation.
REQ-030 reset SHALL take priority over start, mthi and mtlo in the same cycle.

Structure
REQ-031 Package mdu_pkg SHALL hold the op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU), the state enum (IDLE/RUN/DONE), and WIDTH/ITER defaults.
REQ-032 Sub-module mdu_iter_core SHALL hold the 64-bit accumulator plus the one-step multiply/divide datapath; mult_div_unit SHALL hold the FSM, counter, sign handling and HI/LO.

Verification
REQ-033 MULTU input1=FFFFFFFF, input2=FFFFFFFF -> hi=FFFFFFFE, lo=00000001, with done exactly 32 edges after the start edge.
REQ-034 MULT -3 (FFFFFFFD) x 5 -> hi=FFFFFFFF, lo=FFFFFFF1; DIV -7 (FFFFFFF9) / 2 -> lo=FFFFFFFD, hi=FFFFFFFF.
REQ-035 DIVU 100 (00000064) / 0 -> lo=FFFFFFFF, hi=00000064, div_zero=1; the next start clears div_zero.
REQ-036 DIV 80000000 / FFFFFFFF -> lo=80000000, hi=00000000, div_zero=0.
REQ-037 start DIVU 10/3, then at RUN cycle 5 assert start (op MULT) and mthi=1 -> both ignored; result lo=3, hi=1.
REQ-038 Start MULTU 7x9, assert reset at RUN cycle 10 -> next cycle IDLE, busy=0, hi=lo=0, no done pulse; then mtlo with input1=00001234 -> lo=00001234 one edge later.
